// File: rtl/hilo_div_pkg.sv
// Shared definitions for the HI/LO divide sequencer: operation codes,
// sequencer states and default sizing.
package hilo_div_pkg;

    localparam int WIDTH_DEF   = 32;
    localparam int TIMEOUT_DEF = 40;

    localparam logic [1:0] OP_NONE = 2'd0;
    localparam logic [1:0] OP_DIV  = 2'd1;
    localparam logic [1:0] OP_MTHI = 2'd2;
    localparam logic [1:0] OP_MTLO = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // True when the sequencer owns the divider and must hold the CPU.
    function automatic logic is_busy_state(input state_e st);
        return (st == ST_START) || (st == ST_WAIT);
    endfunction

endpackage

// File: rtl/hilo_div_ctrl_if.sv
// Bus between the sequencer and the shared iterative divider.
interface hilo_div_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             div_ena;
    logic             div_start;
    logic [WIDTH-1:0] div_dividend;
    logic [WIDTH-1:0] div_divisor;
    logic             div_busy;
    logic [WIDTH-1:0] div_q;
    logic [WIDTH-1:0] div_r;

    modport master (
        output div_ena, div_start, div_dividend, div_divisor,
        input  div_busy, div_q, div_r
    );

    modport slave (
        input  div_ena, div_start, div_dividend, div_divisor,
        output div_busy, div_q, div_r
    );
endinterface

// File: rtl/hilo_div_ctrl.sv
// Sequencer that owns HI/LO, executes MTHI/MTLO directly and drives the
// shared divider for DIV, with abort and watchdog recovery.
module hilo_div_ctrl
    import hilo_div_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                op_valid,
    input  logic [1:0]          op_code,
    input  logic [WIDTH-1:0]    rs_val,
    input  logic [WIDTH-1:0]    rt_val,
    input  logic                abort,
    output logic                stall,
    output logic                done,
    output logic                div_by_zero,
    output logic                err,
    output logic [WIDTH-1:0]    hi,
    output logic [WIDTH-1:0]    lo,
    hilo_div_ctrl_if.master     div_bus
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_e             state_r;
    state_e             state_s;
    logic [WIDTH-1:0]   hi_r;
    logic [WIDTH-1:0]   lo_r;
    logic [WIDTH-1:0]   hi_d_s;
    logic [WIDTH-1:0]   lo_d_s;
    logic [WIDTH-1:0]   dividend_r;
    logic [WIDTH-1:0]   divisor_r;
    logic               seen_busy_r;
    logic [CNT_W-1:0]   wd_cnt_r;
    logic               latch_s;
    logic               dz_hit_s;
    logic               timeout_s;
    logic               ena_r;
    logic               start_r;
    logic               done_r;
    logic               dz_r;
    logic               err_r;

    // Next-state, HI/LO write data and event decode.
    always_comb begin
        state_s   = state_r;
        hi_d_s    = hi_r;
        lo_d_s    = lo_r;
        latch_s   = 1'b0;
        dz_hit_s  = 1'b0;
        timeout_s = 1'b0;
        if (abort) begin
            state_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (op_valid) begin
                        case (op_code)
                            OP_MTHI: hi_d_s = rs_val;
                            OP_MTLO: lo_d_s = rs_val;
                            OP_DIV: begin
                                if (rt_val == {WIDTH{1'b0}}) begin
                                    dz_hit_s = 1'b1;
                                    state_s  = ST_DONE;
                                end else begin
                                    latch_s  = 1'b1;
                                    state_s  = ST_START;
                                end
                            end
                            default: state_s = ST_IDLE;
                        endcase
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_START: state_s = ST_WAIT;
                ST_WAIT: begin
                    // Completion is only trusted once busy has been seen high.
                    if (seen_busy_r && !div_bus.div_busy) begin
                        hi_d_s  = div_bus.div_r;
                        lo_d_s  = div_bus.div_q;
                        state_s = ST_DONE;
                    end else if (wd_cnt_r == CNT_W'(TIMEOUT - 1)) begin
                        timeout_s = 1'b1;
                        state_s   = ST_IDLE;
                    end else begin
                        state_s = ST_WAIT;
                    end
                end
                ST_DONE: state_s = ST_IDLE;
                default: state_s = ST_IDLE;
            endcase
        end
    end

    // State, architectural HI/LO and operand latches.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            hi_r       <= {WIDTH{1'b0}};
            lo_r       <= {WIDTH{1'b0}};
            dividend_r <= {WIDTH{1'b0}};
            divisor_r  <= {WIDTH{1'b0}};
        end else begin
            state_r <= state_s;
            hi_r    <= hi_d_s;
            lo_r    <= lo_d_s;
            if (latch_s) begin
                dividend_r <= rs_val;
                divisor_r  <= rt_val;
            end
        end
    end

    // Busy-observed flag and watchdog counter for the WAIT phase.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            seen_busy_r <= 1'b0;
            wd_cnt_r    <= {CNT_W{1'b0}};
        end else if (state_r == ST_START) begin
            seen_busy_r <= 1'b0;
            wd_cnt_r    <= {CNT_W{1'b0}};
        end else if (state_r == ST_WAIT) begin
            seen_busy_r <= seen_busy_r | div_bus.div_busy;
            wd_cnt_r    <= wd_cnt_r + CNT_W'(1);
        end
    end

    // Registered control outputs, decoded from the state being entered.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ena_r   <= 1'b0;
            start_r <= 1'b0;
            done_r  <= 1'b0;
            dz_r    <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            ena_r   <= is_busy_state(state_s);
            start_r <= (state_s == ST_START);
            done_r  <= (state_s == ST_DONE);
            dz_r    <= dz_hit_s;
            err_r   <= timeout_s;
        end
    end

    // The IDLE term must react to the request in the same cycle it is presented.
    assign stall = is_busy_state(state_r) ||
                   ((state_r == ST_IDLE) && op_valid && (op_code == OP_DIV));

    assign done                 = done_r;
    assign div_by_zero          = dz_r;
    assign err                  = err_r;
    assign hi                   = hi_r;
    assign lo                   = lo_r;
    assign div_bus.div_ena      = ena_r;
    assign div_bus.div_start    = start_r;
    assign div_bus.div_dividend = dividend_r;
    assign div_bus.div_divisor  = divisor_r;

endmodule

// File: doc/hilo_div_ctrl.md
Name: hilo_div_ctrl

Overview:
Sequencer between the multicycle CPU control unit and the shared 32-cycle iterative signed divider.
- Accepts DIV/MTHI/MTLO operations and owns the architectural HI/LO registers.
- For DIV: latches operands, pulses the divider's start, holds ena and stable operands until the divider's busy falls, then writes HI=remainder, LO=quotient.
- Stalls the CPU for the whole division; handles divide-by-zero, abort (exception flush) and a watchdog timeout.

Parameters:
- TIMEOUT, 40, max cycles spent in WAIT before forced abort with err pulse.
- WIDTH, 32, operand/HI/LO width.

Ports:
- clock  in  1  system clock
- reset  in  1  async active-high reset
- op_valid  in  1  operation request from control unit
- op_code  in  2  operation code: NONE/DIV/MTHI/MTLO
- rs_val  in  WIDTH  dividend, or MTHI/MTLO source
- rt_val  in  WIDTH  divisor
- abort  in  1  sync flush; cancels in-flight DIV
- stall  out  1  CPU must hold state
- done  out  1  one-cycle pulse: DIV result committed or dz reported
- div_by_zero  out  1  one-cycle pulse, coincident with done, when rt_val==0
- err  out  1  one-cycle pulse on watchdog timeout
- hi  out  WIDTH  HI register (MFHI source)
- lo  out  WIDTH  LO register (MFLO source)
- div_ena  out  1  divider enable; low clears the divider
- div_start  out  1  divider start pulse
- div_dividend  out  WIDTH  latched dividend, stable while div_ena
- div_divisor  out  WIDTH  latched divisor, stable while div_ena
- div_busy  in  1  divider busy
- div_q  in  WIDTH  divider quotient
- div_r  in  WIDTH  divider remainder

Behaviour:
- Interface: reset reset, asynchronous, active-high; clock clock.
- Reset values: state=IDLE; hi=lo=0; operand latches=0; stall, done, div_by_zero, err, div_ena, div_start=0; seen_busy=0; wd_cnt=0.
- States: IDLE, START, WAIT, DONE.
- IDLE:
  - op_valid & MTHI: hi<=rs_val next edge; no stall.
  - op_valid & MTLO: lo<=rs_val next edge; no stall.
  - op_valid & DIV & rt_val==0: no divider activity; hi/lo unchanged; ->DONE with div_by_zero flag set.
  - op_valid & DIV & rt_val!=0: latch rs_val/rt_val into div_dividend/div_divisor; ->START.
  - NONE or !op_valid: stay.
- START: div_ena=1, div_start=1 for exactly one cycle; clear seen_busy and wd_cnt; ->WAIT.
- WAIT:
  - div_ena=1, div_start=0; seen_busy<=1 when div_busy=1; wd_cnt increments each cycle.
  - seen_busy & !div_busy: hi<=div_r, lo<=div_q on that edge; ->DONE.
  - wd_cnt==TIMEOUT-1 without completion: err pulse, div_ena drops, ->IDLE, hi/lo unchanged.
- DONE: done=1 for one cycle; div_by_zero=1 if dz path; div_ena=0; ->IDLE. New op accepted the following cycle.
- stall = (state in START, WAIT) | (state==IDLE & op_valid & op_code==DIV). Low in DONE.
- Latency (accept cycle A, nonzero divisor):
  - START at A+1.
  - div_busy high A+2..A+33.
  - capture edge at end of A+34.
  - done at A+35; hi/lo show the result from A+35.
- Divide-by-zero latency: done and div_by_zero at A+1.
- abort: any state ->IDLE on next edge. div_ena=0 that cycle; no done; hi/lo unchanged. Abort beats completion in the same cycle. Abort in IDLE suppresses the op presented that cycle.
- op_valid outside IDLE is ignored.
- Divider operand ports held constant from START through the capture cycle; the divider's sign fix-up is combinational on them.

Decomposition:
- Package hilo_div_pkg: op_code constants (OP_NONE=0, OP_DIV=1, OP_MTHI=2, OP_MTLO=3), state enum, WIDTH default.
- No sub-module. The divider is instantiated by the parent datapath and connected via the div_* ports.

Test Plan:
- DIV 100/7, reference divider attached -> stall A..A+34, done at A+35, lo=14, hi=2, div_start high exactly one cycle.
- DIV -100/7 -> lo=0xFFFFFFF2 (-14), hi=0xFFFFFFFE (-2); DIV 7/-100 -> lo=0, hi=7.
- DIV rs=5, rt=0 -> no div_start, div_by_zero and done at A+1, hi/lo unchanged, stall only in cycle A.
- MTHI 0xDEADBEEF then MTLO 0x12345678 back-to-back -> hi/lo updated on successive edges, stall never high.
- DIV 1000/3 with abort at A+10 -> IDLE at A+11, div_ena low at A+11, hi/lo keep prior values, no done; a following DIV completes correctly.
- Stub divider whose busy never falls -> err pulse when wd_cnt==TIMEOUT-1 (40 cycles in WAIT), then IDLE, stall low, no done.
